// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 inverse cipher: forward key walk to round key 10, then one inverse round per clock.
// Optional round-key-10 cache enabled by defining AES_INV_KEY_CACHE_EN.
module aes128_inv_cipher #(
    parameter int ROUNDS     = 10,
    parameter int DONE_PULSE = 1
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         ED,
    input  logic         DAVAILABLE,
    input  logic [127:0] IN,
    input  logic [127:0] KEY,
    output logic [127:0] OUT,
    output logic         DONE,
    output logic         BUSY
);

    generate
        if (ROUNDS != 10) begin : g_bad_rounds
            $error("aes128_inv_cipher: ROUNDS must be 10");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL} fsm_e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{8'd255 - x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[{8'd255 - x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (row, col) sits at bit offset 127 - 8*(row + 4*col); rows rotate right by their index.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] =
                    inv_sbox(s[127 - 8*(row + 4*((c - row + 4) % 4)) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

    fsm_e         fsm_q;
    logic [3:0]   rc_q;
    logic         done_q;
    logic         busy_q;
    logic [127:0] out_q;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] key_fwd, key_inv;
    logic [127:0] isb, round_out;
    logic [31:0]  w0, w1, w2, w3, iw1, iw2, iw3;
    logic [31:0]  sw_in, rot, sub, tmix, f0, f1, f2, f3;
    logic         cache_hit;
    logic [127:0] cache_rk;

    // One SubWord serves both key directions: forward walk in KEYEXP, backward step afterwards.
    always_comb begin
        w0      = key_q[127:96];
        w1      = key_q[95:64];
        w2      = key_q[63:32];
        w3      = key_q[31:0];
        iw3     = w3 ^ w2;
        iw2     = w2 ^ w1;
        iw1     = w1 ^ w0;
        sw_in   = (fsm_q == S_KEYEXP) ? w3 : iw3;
        rot     = {sw_in[23:0], sw_in[31:24]};
        sub     = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        tmix    = sub ^ {rcon(rc_q), 24'h000000};
        f0      = w0 ^ tmix;
        f1      = w1 ^ f0;
        f2      = w2 ^ f1;
        f3      = w3 ^ f2;
        key_fwd = {f0, f1, f2, f3};
        key_inv = {w0 ^ tmix, iw1, iw2, iw3};
    end

    always_comb begin
        isb       = inv_shift_sub(state_q);
        round_out = inv_mix_cols(isb ^ key_q);
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        if (ED) begin
            case (fsm_q)
                S_IDLE: begin
                    if (DAVAILABLE) begin
                        state_d = IN;
                        key_d   = cache_hit ? cache_rk : KEY;
                    end
                end
                S_KEYEXP: key_d = key_fwd;
                S_INIT: begin
                    state_d = state_q ^ key_q;
                    key_d   = key_inv;
                end
                S_ROUND: begin
                    state_d = round_out;
                    key_d   = key_inv;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; a reset only needs to return the control FSM to IDLE.
    always_ff @(posedge CLOCK) begin
        state_q <= state_d;
        key_q   <= key_d;
    end

`ifdef AES_INV_KEY_CACHE_EN
    logic [127:0] ckey_q;
    logic [127:0] crk_q;
    logic         cvalid_q;

    // rk10 is captured in INIT, but the entry only becomes valid once the walk back to rk0 completes.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cvalid_q <= 1'b0;
        end else if (ED) begin
            if (fsm_q == S_INIT) begin
                cvalid_q <= 1'b0;
            end else if (fsm_q == S_ROUND && rc_q == 4'd1) begin
                cvalid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (ED) begin
            if (fsm_q == S_INIT) begin
                crk_q <= key_q;
            end
            if (fsm_q == S_ROUND && rc_q == 4'd1) begin
                ckey_q <= key_inv;
            end
        end
    end

    assign cache_hit = cvalid_q && (KEY == ckey_q);
    assign cache_rk  = crk_q;
`else
    assign cache_hit = 1'b0;
    assign cache_rk  = KEY;
`endif

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            fsm_q  <= S_IDLE;
            rc_q   <= 4'd0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            out_q  <= '0;
        end else if (ED) begin
            case (fsm_q)
                S_IDLE: begin
                    if (DONE_PULSE != 0) begin
                        done_q <= 1'b0;
                    end
                    if (DAVAILABLE) begin
                        done_q <= 1'b0;
                        busy_q <= 1'b1;
                        if (cache_hit) begin
                            fsm_q <= S_INIT;
                            rc_q  <= 4'd10;
                        end else begin
                            fsm_q <= S_KEYEXP;
                            rc_q  <= 4'd1;
                        end
                    end
                end
                S_KEYEXP: begin
                    if (rc_q == 4'd10) begin
                        fsm_q <= S_INIT;
                    end else begin
                        rc_q <= rc_q + 4'd1;
                    end
                end
                S_INIT: begin
                    rc_q  <= 4'd9;
                    fsm_q <= S_ROUND;
                end
                S_ROUND: begin
                    rc_q <= rc_q - 4'd1;
                    if (rc_q == 4'd1) begin
                        fsm_q <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    out_q  <= isb ^ key_q;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    fsm_q  <= S_IDLE;
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign OUT  = out_q;
    assign DONE = done_q;
    assign BUSY = busy_q;

endmodule
